// File: rtl/uart_rx_ctrl_if.sv
// Receive-result handshake bundle for uart_rx_ctrl.
//   rx_data    : received character (DATA_BITS wide)
//   rx_valid   : rx_data / parity_err / frame_err are valid; held until accepted
//   rx_ready   : consumer accepts the held frame when high together with rx_valid
//   parity_err : parity mismatch on the held frame
//   frame_err  : stop bit sampled low on the held frame
//   overrun    : 1-cycle pulse, a frame completed while the previous one was still held
// master = receiver (uart_rx_ctrl), slave = downstream consumer.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer.
// Detects a start edge on the synchronised line, restarts the baud generator, samples every bit at
// mid-bit using the oversampled baud_tick, assembles the character LSB first, checks parity/stop and
// presents the result on a valid/ready handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   baud_tick   : 1-cycle pulse, OVERSAMPLE per bit period
//   rx_in       : asynchronous serial line, idle high
//   parity_en   : parity bit follows data (latched at start edge)
//   parity_odd  : odd parity when 1, even when 0 (latched at start edge)
//   baud_clr    : 1-cycle pulse restarting the baud generator on a start edge
//   busy        : receiver is not idle
//   rx_if       : result handshake (rx_data, rx_valid, rx_ready, parity_err, frame_err, overrun)
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_tick,
  input  logic            rx_in,
  input  logic            parity_en,
  input  logic            parity_odd,
  output logic            baud_clr,
  output logic            busy,
  uart_rx_ctrl_if.master  rx_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_END = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_s1, rxs, rxs_d;
  logic                 start_edge;
  logic                 samp;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_l, par_odd_l;
  logic                 perr_r, ferr_r;
  logic                 done;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;

  // Two-flop synchroniser plus one delay flop for falling-edge detection. Reset to idle-high so
  // reset release never looks like a start edge; a held-low line (break) never re-triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rxs   <= rx_s1;
      rxs_d <= rxs;
    end
  end

  assign start_edge = rxs_d & ~rxs;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_edge) state_nxt = S_START;
      S_START:  if (samp) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (samp && bit_cnt == LAST_BIT) state_nxt = par_en_l ? S_PARITY : S_STOP;
      S_PARITY: if (samp) state_nxt = S_STOP;
      // Leave at mid-stop so the edge detector is armed for a back-to-back start bit.
      S_STOP:   if (samp) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / sample strobe ----------------
  // The start bit is sampled half a bit after the edge; every later sample is a full bit apart,
  // which keeps all samples centred in their bit.
  always_comb begin
    baud_clr = 1'b0;
    busy     = 1'b1;
    samp     = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        baud_clr = start_edge;
      end
      S_START: samp = baud_tick && (tick_cnt == HALF_END);
      default: samp = baud_tick && (tick_cnt == FULL_END);
    endcase
  end

  // ---------------- frame datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_STOP) && samp;

      if (state == S_IDLE) begin
        if (start_edge) begin
          tick_cnt  <= '0;
          par_en_l  <= parity_en;
          par_odd_l <= parity_odd;
          perr_r    <= 1'b0;          // stays 0 for frames without parity
        end
      end else if (baud_tick) begin
        tick_cnt <= samp ? '0 : tick_cnt + 1'b1;
      end

      if (samp) begin
        case (state)
          S_START:  bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};   // LSB arrives first
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: perr_r <= rxs ^ (^shreg) ^ par_odd_l;
          S_STOP:   ferr_r <= ~rxs;
          default: ;
        endcase
      end
    end
  end

  // ---------------- result hold / handshake ----------------
  // An accept in the completion cycle frees the holding register first, so the new frame loads
  // with no overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done) begin
        if (!valid_q || rx_if.rx_ready) begin
          data_q  <= shreg;
          perr_q  <= perr_r;
          ferr_q  <= ferr_r;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames for each listed behaviour followed by randomized
// frames, all checked against a frame-level model of the held result and overrun count.
module tb_uart_rx_ctrl;
  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int BIT_CLKS = OS * 4;   // baud_tick every 4th clk

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick, rx_in, parity_en, parity_odd, baud_clr, busy;

  uart_rx_ctrl_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .baud_clr   (baud_clr),
    .busy       (busy),
    .rx_if      (rx_if)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: divide by 4, restarted by baud_clr.
  logic [1:0] div;
  always @(posedge clk or posedge rst) begin
    if (rst)           div <= 2'd0;
    else if (baud_clr) div <= 2'd0;
    else               div <= div + 2'd1;
  end
  assign baud_tick = (div == 2'd3);

  // Pulse counters, sampled on the inactive edge.
  int clr_cnt = 0;
  int ovr_cnt = 0;
  always @(negedge clk) begin
    if (baud_clr) clr_cnt++;
    if (rx_if.overrun) ovr_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  int         m_ovr   = 0;

  // Parity error: total ones over data+parity bit disagree with the selected sense.
  function automatic logic exp_perr(input logic [7:0] d, input logic pe, input logic po,
                                    input logic pbit);
    return pe && (($countones({d, pbit}) % 2) != int'(po));
  endfunction

  task automatic model_done(input logic [7:0] d, input logic perr, input logic ferr,
                            input logic acc_same);
    if (m_valid && !acc_same) m_ovr++;
    else begin
      m_valid = 1'b1; m_data = d; m_perr = perr; m_ferr = ferr;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(rx_if.rx_valid),   32'(m_valid));
    chk({tag, ".data"},  32'(rx_if.rx_data),    32'(m_data));
    chk({tag, ".perr"},  32'(rx_if.parity_err), 32'(m_perr));
    chk({tag, ".ferr"},  32'(rx_if.frame_err),  32'(m_ferr));
    chk({tag, ".ovr"},   32'(ovr_cnt),          32'(m_ovr));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                            input logic pbit, input logic stop, input logic scramble);
    parity_en  = pe;
    parity_odd = po;
    drive_bit(1'b0);
    if (scramble) begin   // must not affect the frame already started
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (pe) drive_bit(pbit);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic accept();
    @(negedge clk) rx_if.rx_ready = 1'b1;
    @(negedge clk) rx_if.rx_ready = 1'b0;
    if (m_valid) begin m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; end
  endtask

  // Raise rx_ready exactly in the completion cycle (busy falls at the stop sample, completion
  // is the following cycle).
  task automatic accept_at_done(output logic timed_out);
    int n = 0;
    while (!busy && n < 2000) begin @(negedge clk); n++; end
    while (busy && n < 2000) begin @(negedge clk); n++; end
    timed_out = (n >= 2000);
    rx_if.rx_ready = 1'b1;
    @(negedge clk) rx_if.rx_ready = 1'b0;
  endtask

  initial begin
    int         c0;
    logic       to;
    logic [7:0] d;
    logic       pe, po, pb, sb, rdy;
    int         gap;

    rx_in = 1'b1; parity_en = 1'b0; parity_odd = 1'b0; rx_if.rx_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset.busy", 32'(busy), 0);
    chk("reset.clr",  32'(baud_clr), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: plain frame 0xA5
    c0 = clr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'hA5, 1'b0, 1'b0, 1'b0);
    check_state("a5");
    chk("a5.clr_pulses", 32'(clr_cnt - c0), 1);
    chk("a5.busy", 32'(busy), 0);
    accept();
    check_state("a5.acc");

    // 2: false start, line low only 5 ticks
    c0 = clr_cnt;
    rx_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("fs.busy_mid", 32'(busy), 1);
    repeat (10) @(negedge clk);
    rx_in = 1'b1;
    repeat (60) @(negedge clk);
    chk("fs.busy_end", 32'(busy), 0);
    chk("fs.clr_pulses", 32'(clr_cnt - c0), 1);
    check_state("fs");

    // 3: even parity on 0x3C, wrong then right parity bit, then odd parity
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    model_done(8'h3C, exp_perr(8'h3C, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
    check_state("par_bad");
    accept();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h3C, exp_perr(8'h3C, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
    check_state("par_ok");
    accept();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    model_done(8'h3C, exp_perr(8'h3C, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
    check_state("par_odd");
    accept();

    // 4: stop bit low
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    model_done(8'h55, 1'b0, 1'b1, 1'b0);
    check_state("ferr");
    accept();
    check_state("ferr.acc");

    // 5: overrun, 0x11 held while 0x22 arrives
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h11, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h22, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check_state("ovr");
    accept();
    check_state("ovr.acc");

    // Accept coinciding with completion: new frame loads, no overrun
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h33, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      accept_at_done(to);
    join
    chk("coinc.timeout", 32'(to), 0);
    model_done(8'h44, 1'b0, 1'b0, 1'b1);
    check_state("coinc");
    accept();

    // 6: reset during data bit 4 with a frame held
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h5A, 1'b0, 1'b0, 1'b0);
    check_state("pre_rst");
    parity_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    m_valid = 1'b0; m_data = 8'h00; m_perr = 1'b0; m_ferr = 1'b0;
    check_state("rst_mid");
    chk("rst_mid.busy", 32'(busy), 0);
    chk("rst_mid.clr",  32'(baud_clr), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    model_done(8'h7E, 1'b0, 1'b0, 1'b0);
    check_state("after_rst");
    accept();

    // Break: line held low for 12 bit times
    c0 = clr_cnt;
    rx_in = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    model_done(8'h00, 1'b0, 1'b1, 1'b0);
    check_state("break");
    chk("break.busy", 32'(busy), 0);
    chk("break.clr_pulses", 32'(clr_cnt - c0), 1);
    rx_in = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    accept();

    // Randomized frames: parity settings scrambled mid-frame, back-to-back starts, random accept
    for (int k = 0; k < 16; k++) begin
      d   = 8'($urandom);
      pe  = 1'($urandom_range(0, 1));
      po  = 1'($urandom_range(0, 1));
      pb  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : 1'(^d ^ po);
      sb  = ($urandom_range(0, 4) != 0);
      rdy = 1'($urandom_range(0, 1));
      send_frame(d, pe, po, pb, sb, 1'b1);
      model_done(d, exp_perr(d, pe, po, pb), ~sb, 1'b0);
      check_state($sformatf("rnd%0d", k));
      if (rdy) accept();
      gap = sb ? $urandom_range(0, 40) : BIT_CLKS;
      repeat (gap) @(negedge clk);
    end
    accept();
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
